sqw_pattern_sequencer: RTL and testbench
========================================

Name: sqw_pattern_sequencer

Overview:
- Runtime-programmable square-wave pattern sequencer.
- Holds a small table of (high length, low length, repeat count) entries and steps through them, driving one waveform output.
- One length unit is TICK clocks.
- Sits above the fixed-ratio square-wave generators and replaces hard-wired m/n with a host-written sequence. Supports one-shot or looped playback.

Parameters:
- TICK, 5, clocks per length unit
- DEPTH, 8, number of table entries
- AW, 3, table address width (clog2 DEPTH)
- LEN_W, 4, width of high/low length fields
- REP_W, 4, width of repeat-count field

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  AW  table write address
- cfg_hi  in  LEN_W  high length in units
- cfg_lo  in  LEN_W  low length in units
- cfg_rep  in  REP_W  periods to emit for this entry
- last_idx  in  AW  index of final entry; latched at start
- loop_en  in  1  after last entry, restart at entry 0 instead of finishing
- start  in  1  begin playback (accepted only in IDLE)
- stop  in  1  synchronous abort
- wv  out  1  waveform
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse at end of one-shot playback
- cur_idx  out  AW  entry currently playing
- period_tick  out  1  1-cycle pulse on final cycle of each emitted period

Behaviour:
- Reset (async) values: state=IDLE; wv=0, busy=0, done=0, period_tick=0, cur_idx=0; table contents cleared to 0.
- Table writes occur on any clk edge with cfg_we=1, in any state.
  - An entry is copied into working registers in LOAD.
  - A write to the active entry takes effect at its next LOAD.
- States: IDLE, LOAD, HIGH, LOW, DONE. wv=1 only in HIGH (decoded from the registered state).
- IDLE:
  - start=1 and stop=0 -> LOAD, idx=0, last_idx latched.
  - start ignored in every other state.
  - start and stop both 1 in IDLE -> remain IDLE.
- LOAD: one cycle, wv=0. Latch hi/lo/rep of entry idx and set rep_cnt=0.
  - rep=0, or hi=lo=0 -> entry skipped, go to advance.
  - Else hi>0 -> HIGH for hi*TICK cycles.
  - Else (hi=0) -> LOW for lo*TICK cycles.
- HIGH: on final cycle:
  - lo>0 -> LOW.
  - lo=0 -> end-of-period.
- LOW: on final cycle -> end-of-period.
- End-of-period:
  - period_tick=1 on that final cycle.
  - rep_cnt+1 < rep -> rep_cnt++, re-enter HIGH (or LOW if hi=0) with no gap.
  - Otherwise advance.
- Advance:
  - idx<last_idx -> idx++, LOAD.
  - idx==last_idx and loop_en -> idx=0, LOAD.
  - Otherwise -> DONE.
- DONE: one cycle, done=1, busy still 1, then IDLE.
- Entry boundaries: LOAD inserts exactly one low cycle between entries, including on wrap with loop_en.
- stop=1 in any non-IDLE state -> IDLE next edge. wv=0 from the next cycle; no done or period_tick pulse for the aborted period.
- last_idx latched value >= DEPTH is not possible (AW = clog2 DEPTH). An all-skipped table with loop_en spins one LOAD per entry with wv=0 until stop.
- Phase timer width: clog2(TICK*(2^LEN_W-1)+1); 7 bits at defaults. No overflow permitted.
- loop_en is sampled live at each advance, not latched.

Decomposition:
- Shared package sqw_pkg holds:
  - state enum (IDLE, LOAD, HIGH, LOW, DONE);
  - TICK default;
  - entry struct {hi, lo, rep};
  - function computing timer width.
- Sub-module sqw_phase_timer: loadable down-counter.
  - Inputs: load value, load strobe, enable.
  - Output: last-cycle flag.
  - Used for both HIGH and LOW phases.

Test Plan:
- Entry0 {hi=1, lo=2, rep=2}, last_idx=0, loop_en=0, start in cycle 0 -> LOAD cycle 1; wv=1 cycles 2-6 and 17-21, 0 otherwise; period_tick at cycles 16 and 31; done=1 at cycle 32; busy=1 cycles 1-32 only.
- Entries {hi=1,lo=1,rep=1} and {hi=2,lo=1,rep=1}, last_idx=1 -> high 5 / low 5, one LOAD low cycle, high 10 / low 5, done; cur_idx 0->1 at the second LOAD.
- Entry {hi=0,lo=3,rep=1} then {hi=2,lo=0,rep=1} -> 15 low cycles, then LOAD, then 10 high cycles with period_tick on the 10th, then done; entry with rep=0 inserted between them costs exactly one extra LOAD cycle.
- loop_en=1, single entry {1,1,1} -> repeating pattern: 1 LOAD cycle, high 5, low 5; no done pulse. Assert stop mid-HIGH -> wv=0 and busy=0 next cycle, no done.
- Reset asserted mid-LOW -> all outputs 0 immediately, table cleared. start pressed while busy -> no effect on sequence or cur_idx.
- Rewrite active entry from {1,1,2} to {3,1,2} during its first period -> current repeats unchanged; new values used only at next LOAD of that entry (observed with loop_en=1).

Source files
------------

// File: rtl/sqw_pkg.sv
// -----------------------------------------------------------------------------
// sqw_pkg
// Shared definitions for the square-wave pattern sequencer:
//   - sqw_state_e : sequencer state encoding
//   - SQW_TICK    : default clocks per length unit
//   - sqw_entry_t : one table entry {hi, lo, rep}
//   - sqw_timer_w : phase timer width able to hold the longest phase
// -----------------------------------------------------------------------------
package sqw_pkg;

  localparam int SQW_TICK  = 5;
  localparam int SQW_LEN_W = 4;
  localparam int SQW_REP_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } sqw_state_e;

  typedef struct packed {
    logic [SQW_LEN_W-1:0] hi;
    logic [SQW_LEN_W-1:0] lo;
    logic [SQW_REP_W-1:0] rep;
  } sqw_entry_t;

  // Longest phase is TICK * (2^len_w - 1) cycles; the counter holds
  // (cycles - 1) down to 0, so this width can never overflow.
  function automatic int sqw_timer_w(input int tick, input int len_w);
    return $clog2(tick * ((1 << len_w) - 1) + 1);
  endfunction

endpackage

// File: rtl/sqw_phase_timer.sv
// -----------------------------------------------------------------------------
// sqw_phase_timer
// Loadable down-counter timing one HIGH or LOW phase.
//   clk, reset : clock, asynchronous active-high reset
//   load       : load load_val (takes priority over en)
//   load_val   : phase length in cycles minus one
//   en         : count down while nonzero
//   last       : counter is at zero, i.e. this is the final phase cycle
// -----------------------------------------------------------------------------
module sqw_phase_timer #(
  parameter int W = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         last
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q == '0);

endmodule

// File: rtl/sqw_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// sqw_pattern_sequencer
// Runtime-programmable square-wave pattern sequencer. A host-written table of
// (hi, lo, rep) entries is played back from entry 0 to the latched last index,
// once or in a loop; one length unit is TICK clocks.
//
// Ports:
//   clk, reset        clock, asynchronous active-high reset
//   cfg_we/cfg_addr   table write strobe and address (any state)
//   cfg_hi/lo/rep     entry fields: high units, low units, periods
//   last_idx          final entry index, latched at start
//   loop_en           wrap to entry 0 after the last entry (sampled live)
//   start             begin playback, accepted only in IDLE
//   stop              synchronous abort to IDLE
//   wv                waveform, high only in HIGH
//   busy              any state except IDLE
//   done              one-cycle pulse in DONE (one-shot end)
//   cur_idx           entry currently playing
//   period_tick       final cycle of each emitted period
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for start, wv=0
// LOAD  | one low cycle: copy entry idx into working regs, pick first phase
// HIGH  | wv=1 for hi*TICK cycles
// LOW   | wv=0 for lo*TICK cycles
// DONE  | one cycle done pulse, then IDLE
// -----------------------------------------------------------------------------
module sqw_pattern_sequencer
  import sqw_pkg::*;
#(
  parameter int TICK  = SQW_TICK,
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int LEN_W = SQW_LEN_W,
  parameter int REP_W = SQW_REP_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [LEN_W-1:0] cfg_hi,
  input  logic [LEN_W-1:0] cfg_lo,
  input  logic [REP_W-1:0] cfg_rep,
  input  logic [AW-1:0]    last_idx,
  input  logic             loop_en,
  input  logic             start,
  input  logic             stop,
  output logic             wv,
  output logic             busy,
  output logic             done,
  output logic [AW-1:0]    cur_idx,
  output logic             period_tick
);

  localparam int TW = sqw_timer_w(TICK, LEN_W);

  sqw_state_e      state_q,   state_d;
  logic [AW-1:0]   idx_q,     idx_d;
  logic [AW-1:0]   last_q,    last_d;
  sqw_entry_t      ent_q,     ent_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  sqw_entry_t      tbl_q [DEPTH];
  sqw_entry_t      tbl_d [DEPTH];

  sqw_entry_t      ld_ent;
  logic            tmr_load;
  logic [TW-1:0]   tmr_val;
  logic            tmr_en;
  logic            tmr_last;
  logic            eop;
  logic            advance;
  logic            enter_hi;
  logic            enter_lo;
  logic            period_tick_c;

  // Timer holds (cycles - 1); callers guarantee len >= 1.
  function automatic logic [TW-1:0] phase_len(input logic [LEN_W-1:0] len);
    return TW'(int'(len) * TICK - 1);
  endfunction

  // Table write port: any state, takes effect at the next LOAD of that entry.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      tbl_d[i] = tbl_q[i];
    end
    if (cfg_we) begin
      tbl_d[cfg_addr] = '{hi: cfg_hi, lo: cfg_lo, rep: cfg_rep};
    end
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    last_d        = last_q;
    ent_d         = ent_q;
    rep_cnt_d     = rep_cnt_q;
    tmr_load      = 1'b0;
    tmr_val       = '0;
    eop           = 1'b0;
    advance       = 1'b0;
    enter_hi      = 1'b0;
    enter_lo      = 1'b0;
    ld_ent        = tbl_q[idx_q];

    unique case (state_q)
      ST_IDLE: begin
        if (start && !stop) begin
          state_d = ST_LOAD;
          idx_d   = '0;
          last_d  = last_idx;
        end
      end
      ST_LOAD: begin
        ent_d     = ld_ent;
        rep_cnt_d = '0;
        if ((ld_ent.rep == '0) || ((ld_ent.hi == '0) && (ld_ent.lo == '0))) begin
          advance = 1'b1;
        end else if (ld_ent.hi != '0) begin
          enter_hi = 1'b1;
        end else begin
          enter_lo = 1'b1;
        end
      end
      ST_HIGH: begin
        if (tmr_last) begin
          if (ent_q.lo != '0) begin
            enter_lo = 1'b1;
          end else begin
            eop = 1'b1;
          end
        end
      end
      ST_LOW: begin
        if (tmr_last) begin
          eop = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // End of period: repeat the entry back-to-back or move on.
    if (eop) begin
      if (({1'b0, rep_cnt_q} + 1'b1) < {1'b0, ent_q.rep}) begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (ent_q.hi != '0) begin
          enter_hi = 1'b1;
        end else begin
          enter_lo = 1'b1;
        end
      end else begin
        advance = 1'b1;
      end
    end

    if (advance) begin
      if (idx_q < last_q) begin
        idx_d   = idx_q + 1'b1;
        state_d = ST_LOAD;
      end else if (loop_en) begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end else begin
        state_d = ST_DONE;
      end
    end

    // ent_d carries the freshly loaded entry in LOAD and ent_q otherwise.
    if (enter_hi) begin
      state_d  = ST_HIGH;
      tmr_load = 1'b1;
      tmr_val  = phase_len(ent_d.hi);
    end else if (enter_lo) begin
      state_d  = ST_LOW;
      tmr_load = 1'b1;
      tmr_val  = phase_len(ent_d.lo);
    end

    period_tick_c = eop;

    // Abort wins over everything; the interrupted period reports nothing.
    if (stop && (state_q != ST_IDLE)) begin
      state_d       = ST_IDLE;
      tmr_load      = 1'b0;
      period_tick_c = 1'b0;
    end
  end

  assign tmr_en = (state_q == ST_HIGH) || (state_q == ST_LOW);

  sqw_phase_timer #(
    .W(TW)
  ) u_phase_timer (
    .clk     (clk),
    .reset   (reset),
    .load    (tmr_load),
    .load_val(tmr_val),
    .en      (tmr_en),
    .last    (tmr_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= '0;
      ent_q     <= '0;
      rep_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      ent_q     <= ent_d;
      rep_cnt_q <= rep_cnt_d;
      for (int i = 0; i < DEPTH; i++) begin
        tbl_q[i] <= tbl_d[i];
      end
    end
  end

  assign wv          = (state_q == ST_HIGH);
  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign cur_idx     = idx_q;
  assign period_tick = period_tick_c;

endmodule

// File: tb/tb_sqw_pattern_sequencer.sv
module tb_sqw_pattern_sequencer;

  localparam int TICK  = 5;
  localparam int DEPTH = 8;
  localparam int AW    = 3;
  localparam int LEN_W = 4;
  localparam int REP_W = 4;
  localparam int BIG   = 1000000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             cfg_we = 1'b0;
  logic [AW-1:0]    cfg_addr = '0;
  logic [LEN_W-1:0] cfg_hi = '0;
  logic [LEN_W-1:0] cfg_lo = '0;
  logic [REP_W-1:0] cfg_rep = '0;
  logic [AW-1:0]    last_idx = '0;
  logic             loop_en = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             wv;
  logic             busy;
  logic             done;
  logic [AW-1:0]    cur_idx;
  logic             period_tick;

  int n_cmp = 0;
  int n_bad = 0;

  // Bench-side copy of the table and the expected per-cycle trace.
  int m_hi [DEPTH];
  int m_lo [DEPTH];
  int m_rep[DEPTH];
  int exp_q[$];

  typedef struct {
    int h0, l0, r0, h1, l1, r1, h2, l2, r2;
    int last;
    int busy_cyc, hi_cyc, ticks, end_idx;
  } vec_t;
  vec_t vecs[7];

  sqw_pattern_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_hi     (cfg_hi),
    .cfg_lo     (cfg_lo),
    .cfg_rep    (cfg_rep),
    .last_idx   (last_idx),
    .loop_en    (loop_en),
    .start      (start),
    .stop       (stop),
    .wv         (wv),
    .busy       (busy),
    .done       (done),
    .cur_idx    (cur_idx),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_cmp=%0d want finished", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int pack(input bit w, input bit b, input bit d, input bit t, input int idx);
    return (int'(w) << 6) | (int'(b) << 5) | (int'(d) << 4) | (int'(t) << 3) | idx;
  endfunction

  function automatic int dut_vec();
    return pack(wv, busy, done, period_tick, int'(cur_idx));
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", nm, $time, act, exp);
    end
  endtask

  task automatic write_entry(input int a, input int h, input int l, input int r);
    cfg_we   = 1'b1;
    cfg_addr = AW'(a);
    cfg_hi   = LEN_W'(h);
    cfg_lo   = LEN_W'(l);
    cfg_rep  = REP_W'(r);
    step();
    cfg_we   = 1'b0;
    m_hi[a]  = h;
    m_lo[a]  = l;
    m_rep[a] = r;
  endtask

  // Expected trace from the table's rules: a LOAD cycle per entry, then rep
  // periods of hi*TICK high and lo*TICK low cycles, tick on each period's end.
  task automatic build_model(input int last, input bit loop, input int maxlen);
    int idx;
    int v;
    idx = 0;
    exp_q.delete();
    forever begin
      exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, idx));
      if (exp_q.size() >= maxlen) break;
      if (m_rep[idx] != 0 && (m_hi[idx] + m_lo[idx]) != 0) begin
        for (int r = 0; r < m_rep[idx]; r++) begin
          for (int k = 0; k < m_hi[idx] * TICK; k++) exp_q.push_back(pack(1'b1, 1'b1, 1'b0, 1'b0, idx));
          for (int k = 0; k < m_lo[idx] * TICK; k++) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, idx));
          v = exp_q.pop_back();
          exp_q.push_back(v | 8);
        end
      end
      if (idx < last) idx++;
      else if (loop) idx = 0;
      else begin
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 1'b0, idx));
        break;
      end
      if (exp_q.size() >= maxlen) break;
    end
    while (exp_q.size() > maxlen) void'(exp_q.pop_back());
  endtask

  // Start playback and compare every cycle against exp_q. With noise, start
  // and last_idx are toggled while busy; both must be ignored.
  task automatic run_trace(input string nm, input bit noise, input int last);
    last_idx = last[AW-1:0];
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (noise) begin
        start    = 1'($urandom);
        last_idx = AW'($urandom);
      end
      check(nm, dut_vec(), exp_q[i]);
      if (i == exp_q.size() - 1) start = 1'b0;
      step();
    end
    start = 1'b0;
    last_idx = last[AW-1:0];
  endtask

  initial begin
    int bcnt, hcnt, tcnt, dcnt, eidx, guard, ph, lst;
    bit lp;
    int first[$];

    vecs[0] = '{1,1,1,  2,1,1,  0,0,0,  1, 28,   15,   2,  1};
    vecs[1] = '{0,3,1,  2,0,1,  0,0,0,  1, 28,   10,   2,  1};
    vecs[2] = '{0,3,1,  1,1,0,  2,0,1,  2, 29,   10,   2,  2};
    vecs[3] = '{1,2,2,  0,0,0,  0,0,0,  0, 32,   10,   2,  0};
    vecs[4] = '{0,0,3,  0,0,0,  0,0,0,  0, 2,    0,    0,  0};
    vecs[5] = '{15,15,15, 0,0,0, 0,0,0, 0, 2252, 1125, 15, 0};
    vecs[6] = '{3,0,4,  0,0,0,  1,1,0,  2, 64,   60,   4,  2};
    for (int i = 0; i < DEPTH; i++) begin
      m_hi[i] = 0; m_lo[i] = 0; m_rep[i] = 0;
    end

    // Reset state
    step();
    check("reset_outputs", dut_vec(), 0);
    reset = 1'b0;
    step();
    check("idle_after_reset", dut_vec(), 0);

    // Single entry {1,2,2}: exact cycle map
    write_entry(0, 1, 2, 2);
    loop_en = 1'b0;
    last_idx = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 34; c++) begin
      check("single_entry_cycle", dut_vec(),
            pack((c >= 2 && c <= 6) || (c >= 17 && c <= 21), c <= 32, c == 32,
                 c == 16 || c == 31, 0));
      step();
    end

    // Vector table: aggregate behaviour of short programs
    for (int v = 0; v < 7; v++) begin
      write_entry(0, vecs[v].h0, vecs[v].l0, vecs[v].r0);
      write_entry(1, vecs[v].h1, vecs[v].l1, vecs[v].r1);
      write_entry(2, vecs[v].h2, vecs[v].l2, vecs[v].r2);
      loop_en = 1'b0;
      last_idx = AW'(vecs[v].last);
      start = 1'b1;
      step();
      start = 1'b0;
      bcnt = 0; hcnt = 0; tcnt = 0; dcnt = 0; eidx = -1; guard = 0;
      while (busy && guard < 4000) begin
        bcnt++;
        hcnt += int'(wv);
        tcnt += int'(period_tick);
        if (done) begin
          dcnt++;
          eidx = int'(cur_idx);
        end
        guard++;
        step();
      end
      check("vec_busy_cycles", bcnt, vecs[v].busy_cyc);
      check("vec_high_cycles", hcnt, vecs[v].hi_cyc);
      check("vec_period_ticks", tcnt, vecs[v].ticks);
      check("vec_done_pulses", dcnt, 1);
      check("vec_done_idx", eidx, vecs[v].end_idx);
    end

    // Looped single entry {1,1,1}, then stop in the middle of HIGH
    write_entry(0, 1, 1, 1);
    loop_en = 1'b1;
    last_idx = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 36; c++) begin
      ph = (c - 1) % 11;
      check("loop_pattern", dut_vec(), pack(ph >= 1 && ph <= 5, 1'b1, 1'b0, ph == 10, 0));
      if (c == 36) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    check("stop_mid_high", dut_vec(), 0);
    step();
    check("stop_stays_idle", dut_vec(), 0);

    // Rewrite the active entry during its first period (looped)
    write_entry(0, 1, 1, 2);
    build_model(0, 1'b1, 21);
    first = exp_q;
    m_hi[0] = 3;
    build_model(0, 1'b1, 42);
    exp_q = {first, exp_q};
    m_hi[0] = 1;
    loop_en = 1'b1;
    last_idx = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 63; c++) begin
      if (c == 3) begin
        cfg_we = 1'b1; cfg_addr = '0; cfg_hi = 4'd3; cfg_lo = 4'd1; cfg_rep = 4'd2;
      end else begin
        cfg_we = 1'b0;
      end
      check("rewrite_active", dut_vec(), exp_q[c-1]);
      step();
    end
    m_hi[0] = 3;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("rewrite_stop_busy", int'(busy), 0);
    loop_en = 1'b0;

    // start and stop together in IDLE
    start = 1'b1;
    stop = 1'b1;
    step();
    check("start_stop_idle", int'(busy), 0);
    step();
    check("start_stop_idle2", int'(busy), 0);
    start = 1'b0;
    stop = 1'b0;

    // start / last_idx pokes while busy are ignored
    write_entry(0, 1, 1, 1);
    write_entry(1, 2, 1, 1);
    build_model(1, 1'b0, BIG);
    run_trace("busy_start_ignored", 1'b1, 1);
    check("busy_start_end", int'(busy), 0);

    // Randomized programs against the reference model
    for (int it = 0; it < 25; it++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 2) != 0)
          write_entry(a, $urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 3));
      end
      lst = $urandom_range(0, DEPTH - 1);
      lp = ($urandom_range(0, 3) == 0);
      loop_en = lp;
      build_model(lst, lp, lp ? 200 : BIG);
      run_trace("random_trace", 1'b1, lst);
      if (lp) begin
        stop = 1'b1;
        step();
        stop = 1'b0;
      end
      check("random_end_idle", int'(busy), 0);
    end
    loop_en = 1'b0;

    // Asynchronous reset in the middle of LOW, then table must be empty
    write_entry(0, 1, 1, 1);
    last_idx = '0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c < 8; c++) step();
    check("pre_reset_low", dut_vec(), pack(1'b0, 1'b1, 1'b0, 1'b0, 0));
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", dut_vec(), 0);
    step();
    reset = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_hi[i] = 0; m_lo[i] = 0; m_rep[i] = 0;
    end
    step();
    build_model(DEPTH - 1, 1'b0, BIG);
    run_trace("table_cleared", 1'b0, DEPTH - 1);
    check("table_cleared_end", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
